// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply/divide unit for the execute stage.
//   MULT/MULTU : radix-2 shift-add, 32 iterations, full 64-bit product.
//   DIV/DIVU   : radix-2 restoring division, 32 iterations.
// Both iterate on operand magnitudes. The sign fix-up is applied as the
// result is written into hi/lo on the edge that enters DONE.
// Build option: define MULDIV_FAST_MUL_EN to let multiplies complete in a
// single cycle through a combinational multiplier (IDLE -> DONE directly).
// Divide timing is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | one radix-2 iteration per cycle, counter 0..31
// DONE  | hi/lo hold the new result, done pulses, busy released
module muldiv #(
  parameter logic [31:0] ZERO_DIV_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  // Low half: multiplier / dividend magnitude, shifted out one bit per cycle.
  // High half: partial product / partial remainder.
  logic [63:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [31:0] opb_q, opb_d;
  // Raw dividend, returned in hi on divide-by-zero.
  logic [31:0] dvd_q, dvd_d;
  logic        bzero_q, bzero_d;
  // Negate product / quotient at the end.
  logic        qneg_q, qneg_d;
  // Negate remainder at the end (dividend was negative).
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand conditioning for the incoming instruction.
  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[31];
  assign b_neg     = op_signed & b[31];
  // 32'h8000_0000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;

  // One iteration of each algorithm, computed from the current accumulator.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] iter_next;

  // Datapath for a single shift-add or restoring-subtract step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Shift the next dividend bit into the partial remainder.
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_ok   = (div_sh >= {1'b0, opb_q});
    // When div_ok the difference is below the divisor, so 32 bits suffice.
    div_rem  = div_ok ? (div_sh[31:0] - opb_q) : div_sh[31:0];
    div_next = {div_rem, acc_q[30:0], div_ok};

    iter_next = is_div_q ? div_next : mul_next;
  end

  // Sign fix-up and divide-by-zero override applied to the final iteration.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Result formation for the write into hi/lo on entry to DONE.
  always_comb begin
    prod_fix = qneg_q ? (64'd0 - iter_next) : iter_next;
    quo_fix  = qneg_q ? (32'd0 - iter_next[31:0]) : iter_next[31:0];
    rem_fix  = rneg_q ? (32'd0 - iter_next[63:32]) : iter_next[63:32];
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_q) begin
      if (bzero_q) begin
        res_hi = dvd_q;
        res_lo = ZERO_DIV_QUOT;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiplier: sign- or zero-extend to 64 bits; the low
  // 64 bits of the product are exact for both signed and unsigned forms.
  logic [63:0] fast_a;
  logic [63:0] fast_b;
  logic [63:0] fast_p;

  assign fast_a = {{32{op_signed & a[31]}}, a};
  assign fast_b = {{32{op_signed & b[31]}}, b};
  assign fast_p = fast_a * fast_b;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    bzero_d  = bzero_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          is_div_d = op[1];
          acc_d    = {32'd0, a_mag};
          opb_d    = b_mag;
          dvd_d    = a;
          bzero_d  = (b == 32'd0);
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = 5'd0;
          state_d  = RUN;
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            hi_d    = fast_p[63:32];
            lo_d    = fast_p[31:0];
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        if (flush) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          acc_d = iter_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            cnt_d   = 5'd0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // start is ignored here; the stalled instruction advances this cycle.
        state_d = IDLE;
      end

      default: begin
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      dvd_q    <= 32'd0;
      bzero_q  <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      bzero_q  <= bzero_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // busy is gated by reset so it drops immediately, even with start high.
  assign busy = ~reset & (((state_q == IDLE) & start & ~flush) | (state_q == RUN));
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed and random checks of muldiv against an arithmetic
// reference model (64-bit integer multiply, truncating divide).
module tb_muldiv;

  localparam logic [31:0] ZDQ = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  muldiv #(.ZERO_DIV_QUOT(ZDQ)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy, sr;
    logic [63:0] ux, uy, r, q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: begin
        sr = sx * sy;
        r  = sr;
      end
      2'd1: r = ux * uy;
      2'd2: begin
        if (y == 32'd0) r = {x, ZDQ};
        else begin
          sr = sx / sy;
          q  = sr;
          sr = sx % sy;
          m  = sr;
          r  = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, ZDQ};
        else begin
          q = ux / uy;
          m = ux % uy;
          r = {m[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is 1 time unit after a rising edge with the unit in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    logic [63:0] exp;
    int n;
    int exp_n;
    exp   = model(o, x, y);
    exp_n = 32;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) exp_n = 0;
`endif
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    flush = 1'b0;
    #1;
    check({tag, "_busy_accept"}, {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      n++;
    end
    // Cycles after the accepting cycle = n + 1.
    check({tag, "_latency"}, n + 1, exp_n + 1);
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_result"}, {hi, lo}, exp);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] prior;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    flush  = 1'b0;

    // Reset state, including busy held low with start asserted.
    #2;
    start = 1'b1;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Directed vectors.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'd3, 32'h0000_0064, 32'h0000_0000, "divu_zero");
    run_op(2'd2, 32'h8000_0005, 32'h0000_0000, "div_zero");
    run_op(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, "div_negb");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");

    // Flush at accept+10 of DIVU 10/3; prior result is DIV -7/2.
    prior = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd10;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    check("flush_no_done", {63'd0, done}, 64'd0);
    check("flush_hilo_held", {hi, lo}, prior);
    @(posedge clk);
    #1;
    check("flush_no_done2", {63'd0, done}, 64'd0);
    check("flush_hilo_held2", {hi, lo}, prior);
    run_op(2'd3, 32'd10, 32'd3, "divu_after_flush");

    // start held high from acceptance through DONE.
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_latency", n + 1, 33);
    check("hold_busy_done", {63'd0, busy}, 64'd0);
    check("hold_result", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    start  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("hold_one_pulse", pulses, 0);
    check("hold_busy_idle", {63'd0, busy}, 64'd0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 15));
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, rx, ry, "rand");
    end

    // Asynchronous reset at accept+5 of a divide.
    run_op(2'd3, 32'd100, 32'd7, "pre_reset");
    start = 1'b1;
    op    = 2'd2;
    a     = 32'h1234_5678;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("arst_no_done", pulses, 0);
    check("arst_hilo_after", {hi, lo}, 64'd0);
    run_op(2'd0, 32'h0001_0000, 32'hFFFF_0000, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have one parameter: ZERO_DIV_QUOT, default 32'hFFFF_FFFF, the lo value produced on divide-by-zero.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  execute stage holds a valid mul/div instruction.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  in  32  rs operand; dividend for DIV/DIVU.
REQ-007 b  in  32  rt operand; divisor for DIV/DIVU.
REQ-008 flush  in  1  abort any operation in progress (exception or redirect).
REQ-009 busy  out  1  stall request to the hazard unit.
REQ-010 done  out  1  single-cycle pulse; hi/lo hold a new result.
REQ-011 hi  out  32  product high word, or remainder.
REQ-012 lo  out  32  product low word, or quotient.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 start SHALL be sampled only in IDLE; with flush=0, op, a and b are captured and the FSM enters RUN with iteration counter 0.
REQ-015 RUN SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring subtract for divide, both on operand magnitudes.
REQ-016 After 32 RUN cycles the FSM SHALL enter DONE, so done is high exactly 33 cycles after the accepting cycle.
REQ-017 DONE SHALL last one cycle, assert done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-018 busy SHALL be (IDLE & start & ~flush) | RUN; busy SHALL be 0 in DONE so the stalled instruction advances.
REQ-019 hi and lo SHALL be registered, update only on the edge entering DONE, and hold until the next DONE.
REQ-020 Signed ops: product negated when operand signs differ; quotient negated when signs differ; remainder takes the dividend's sign.
REQ-021 MULT/MULTU SHALL produce the full 64-bit product {hi,lo}, with no truncation or overflow flag.
REQ-022 DIV/DIVU with b==0 SHALL yield lo=ZERO_DIV_QUOT and hi=a, with the same latency.
REQ-023 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000 and hi=0.
REQ-024 flush SHALL move the FSM to IDLE on the next edge from any state: done not asserted, hi/lo unchanged.
REQ-025 flush has priority over start in the same cycle.

Reset
REQ-026 Reset SHALL force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0 immediately, regardless of clk.
REQ-027 Reset mid-operation SHALL discard the operation; no done pulse follows reset release.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU SHALL go IDLE->DONE directly using a single-cycle multiplier, so done comes 1 cycle after acceptance and busy is high only in the accepting cycle.
REQ-029 When MULDIV_FAST_MUL_EN is undefined, multiplies SHALL use the 32-iteration path; divide timing SHALL be identical in both builds.

Verification
REQ-030 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done at accept+33 (accept+1 with MULDIV_FAST_MUL_EN).
REQ-031 MULT a=FFFFFFFE (-2) b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA.
REQ-032 DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=00000064 b=0 -> lo=FFFFFFFF, hi=00000064.
REQ-033 DIVU 10/3 with flush pulsed at accept+10 -> busy=0 from accept+11, no done, hi/lo keep prior values; a new start at accept+12 completes normally (lo=3, hi=1).
REQ-034 start held high from acceptance through DONE -> exactly one done pulse, and busy drops in the DONE cycle.
REQ-035 reset asserted at accept+5 -> all outputs 0 asynchronously; no done after release.
